// File: rtl/dsp_alu_req_sequencer.sv
// Two-client front end for the 4-bit sequential ALU: arbitrates, clears the ALU,
// streams a/b/op nibbles, waits for done (with timeout) and returns a response.
module dsp_alu_req_sequencer #(
  parameter int unsigned TIMEOUT    = 4,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic [3:0] req0_a_i,
  input  logic [3:0] req0_b_i,
  input  logic [3:0] req0_op_i,
  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic [3:0] req1_a_i,
  input  logic [3:0] req1_b_i,
  input  logic [3:0] req1_op_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [3:0] rsp_result_o,
  output logic [3:0] rsp_flags_o,
  output logic       rsp_err_o,
  output logic       alu_reset_o,
  output logic [3:0] alu_data_o,
  input  logic [3:0] alu_result_i,
  input  logic [3:0] alu_flags_i,
  output logic [7:0] txn_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_OP1, S_OP2, S_OPC, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] TO = 4'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic       id_q, id_d;
  logic       last_q, last_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] res_q, res_d, flg_q, flg_d;
  logic       err_q, err_d;
  logic [7:0] txn_q, txn_d;
  logic       gnt0, gnt1;
  logic [3:0] wcnt_inc;

  // last_q holds the most recent winner; requester 0 wins a tie unless it won last.
  assign gnt0     = req0_valid_i & (FIXED_PRIO | ~req1_valid_i | last_q);
  assign gnt1     = req1_valid_i & ~gnt0;
  assign wcnt_inc = wcnt_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      wcnt_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    err_d   = err_q;
    txn_d   = txn_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          a_d     = gnt0 ? req0_a_i  : req1_a_i;
          b_d     = gnt0 ? req0_b_i  : req1_b_i;
          op_d    = gnt0 ? req0_op_i : req1_op_i;
          id_d    = gnt1;
          last_d  = gnt1;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_OP1;
      S_OP1: state_d = S_OP2;
      S_OP2: state_d = S_OPC;
      S_OPC: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes precedence over a timeout landing on the same cycle
        if (alu_flags_i[0]) begin
          res_d   = alu_result_i;
          flg_d   = alu_flags_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == TO) begin
            res_d   = '0;
            flg_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          txn_d   = txn_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_data_o = '0;
    if (!reset_i) begin
      case (state_q)
        S_OP1:   alu_data_o = a_q;
        S_OP2:   alu_data_o = b_q;
        S_OPC:   alu_data_o = op_q;
        default: alu_data_o = '0;
      endcase
    end
  end

  assign req0_ready_o = (state_q == S_IDLE) & ~reset_i & gnt0;
  assign req1_ready_o = (state_q == S_IDLE) & ~reset_i & gnt1;
  assign alu_reset_o  = reset_i | (state_q == S_CLR);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
  assign rsp_flags_o  = flg_q;
  assign rsp_err_o    = err_q;
  assign txn_count_o  = txn_q;

endmodule
